// File: rtl/alu_pkg.sv
// Shared ALU/writeback types: opcode encoding, writeback FSM states, datapath width.
package alu_pkg;

  localparam int W = 8;

  typedef enum logic [2:0] {
    AND = 3'b000,
    XOR = 3'b001,
    SHL = 3'b010,
    SHR = 3'b011,
    ADD = 3'b100
  } alu_op_t;

  typedef enum logic {
    RUN     = 1'b0,
    TRAPPED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Result beat from the ALU into the writeback stage (valid/ready handshake).
interface alu_writeback_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic          WB_VALID;
  logic          WB_READY;
  logic [2:0]    WB_OP;       // raw opcode bits; out-of-range codes must pass through
  logic          WB_WEN;
  logic [AW-1:0] WB_DEST;
  logic [W-1:0]  WB_DATA;
  logic [1:0]    WB_OVERFLOW;
  logic          WB_ZF;
  logic          WB_TRAP;

  modport master (
    output WB_VALID, WB_OP, WB_WEN, WB_DEST, WB_DATA, WB_OVERFLOW, WB_ZF, WB_TRAP,
    input  WB_READY
  );

  modport slave (
    input  WB_VALID, WB_OP, WB_WEN, WB_DEST, WB_DATA, WB_OVERFLOW, WB_ZF, WB_TRAP,
    output WB_READY
  );
endinterface

// File: rtl/alu_writeback_reg_file.sv
// NREGS x W register file: one synchronous write port, two combinational read
// ports with no write bypass (same-cycle read of the written entry sees old data).
module reg_file #(
  parameter  int NREGS = 8,
  parameter  int W     = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2
);

  logic [NREGS-1:0][W-1:0] mem;

  // Storage: synchronous clear, then single write port.
  always_ff @(posedge clk) begin
    if (rst)     mem     <= '0;
    else if (we) mem[wa] <= wd;
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits results to the register file, latches ADD flags,
// counts retired beats, and halts on a shift-of-zero trap until acknowledged.
module alu_writeback #(
  parameter  int NREGS = 8,
  parameter  int W     = alu_pkg::W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          CLK,
  input  logic          RESET,
  alu_writeback_if.slave wb,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic [W-1:0]  RD1,
  output logic [W-1:0]  RD2,
  output logic          CF,
  output logic          ZF,
  output logic          TRAPPED,
  input  logic          TRAP_ACK,
  output logic [7:0]    TRAP_COUNT,
  output logic [15:0]   RETIRED
);
  import alu_pkg::*;

  wb_state_t state, state_nxt;
  logic      acc, is_shift, trap_beat, commit;

  assign acc       = wb.WB_VALID && wb.WB_READY;
  assign is_shift  = (wb.WB_OP == 3'(SHL)) || (wb.WB_OP == 3'(SHR));
  // A trap flag on a non-shift opcode is not a real trap and is ignored.
  assign trap_beat = acc && wb.WB_TRAP && is_shift;
  assign commit    = acc && !trap_beat;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= alu_pkg::RUN;
    else       state <= state_nxt;
  end

  // Next-state: trap beat halts, TRAP_ACK releases (no effect while running).
  always_comb begin
    state_nxt = state;
    case (state)
      alu_pkg::RUN:     if (trap_beat) state_nxt = alu_pkg::TRAPPED;
      alu_pkg::TRAPPED: if (TRAP_ACK)  state_nxt = alu_pkg::RUN;
      default:          state_nxt = alu_pkg::RUN;
    endcase
  end

  // Ready depends on state only, so upstream valid never loops back into it.
  assign wb.WB_READY = (state == alu_pkg::RUN);
  assign TRAPPED     = (state == alu_pkg::TRAPPED);

  // Flags follow ADD results only; independent of whether the result is written.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CF <= 1'b0;
      ZF <= 1'b0;
    end else if (commit && wb.WB_OP == 3'(ADD)) begin
      CF <= |wb.WB_OVERFLOW;
      ZF <= wb.WB_ZF;
    end
  end

  // Retired count wraps; trap count saturates at 255.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RETIRED    <= '0;
      TRAP_COUNT <= '0;
    end else begin
      if (commit) RETIRED <= RETIRED + 16'd1;
      if (trap_beat && TRAP_COUNT != 8'hFF) TRAP_COUNT <= TRAP_COUNT + 8'd1;
    end
  end

  reg_file #(.NREGS(NREGS), .W(W)) u_rf (
    .clk (CLK),
    .rst (RESET),
    .we  (commit && wb.WB_WEN),
    .wa  (wb.WB_DEST),
    .wd  (wb.WB_DATA),
    .ra1 (RA1),
    .ra2 (RA2),
    .rd1 (RD1),
    .rd2 (RD2)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: inputs driven 1ns after the rising edge,
// outputs sampled before the next edge.
module tb_alu_writeback;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ra1, ra2;
  logic [7:0] rd1, rd2;
  logic       cf, zf, trapped, trap_ack;
  logic [7:0] trap_count;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  alu_writeback_if #(.W(8), .AW(3)) wb ();

  alu_writeback #(.NREGS(8), .W(8)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .wb         (wb),
    .RA1        (ra1),
    .RA2        (ra2),
    .RD1        (rd1),
    .RD2        (rd2),
    .CF         (cf),
    .ZF         (zf),
    .TRAPPED    (trapped),
    .TRAP_ACK   (trap_ack),
    .TRAP_COUNT (trap_count),
    .RETIRED    (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] op, input logic wen, input logic [2:0] dest,
                      input logic [7:0] data, input logic [1:0] ov, input logic z,
                      input logic trap);
    wb.WB_VALID    = 1'b1;
    wb.WB_OP       = op;
    wb.WB_WEN      = wen;
    wb.WB_DEST     = dest;
    wb.WB_DATA     = data;
    wb.WB_OVERFLOW = ov;
    wb.WB_ZF       = z;
    wb.WB_TRAP     = trap;
  endtask

  task automatic idle();
    wb.WB_VALID = 1'b0;
    wb.WB_TRAP  = 1'b0;
    wb.WB_WEN   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    trap_ack = 0; ra1 = 0; ra2 = 0;
    rst = 1; tick(); tick(); rst = 0; #1;
    vectors++;
    if ({wb.WB_READY, trapped, cf, zf} !== 4'b1000) begin
      miscompares++; $display("FAIL reset_ctl: got %b expected 1000", {wb.WB_READY, trapped, cf, zf});
    end
    vectors++;
    if (trap_count !== 8'd0 || retired !== 16'd0) begin
      miscompares++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", trap_count, retired);
    end
  endtask

  task automatic test_write_read();
    beat(3'(XOR), 1, 3, 8'hA5, 2'b00, 0, 0);
    ra1 = 3; #1;
    vectors++;
    if (rd1 !== 8'h00) begin
      miscompares++; $display("FAIL same_cycle_read: got %h expected 00", rd1);
    end
    tick(); idle(); #1;
    vectors++;
    if (rd1 !== 8'hA5) begin
      miscompares++; $display("FAIL write_r3: got %h expected a5", rd1);
    end
    vectors++;
    if (retired !== 16'd1) begin
      miscompares++; $display("FAIL retired_1: got %0d expected 1", retired);
    end
  endtask

  task automatic test_back_to_back();
    beat(3'(AND), 1, 0, 8'h5A, 2'b00, 0, 0); tick();
    beat(3'(SHR), 1, 1, 8'hC3, 2'b00, 0, 0); tick();
    idle(); ra1 = 0; ra2 = 1; #1;
    vectors++;
    if (rd1 !== 8'h5A || rd2 !== 8'hC3) begin
      miscompares++; $display("FAIL b2b_r0_r1: got %h/%h expected 5a/c3", rd1, rd2);
    end
    vectors++;
    if (retired !== 16'd3) begin
      miscompares++; $display("FAIL retired_3: got %0d expected 3", retired);
    end
  endtask

  task automatic test_add_flags();
    beat(3'(ADD), 0, 0, 8'h00, 2'b01, 1, 0); tick(); idle(); #1;
    vectors++;
    if ({cf, zf} !== 2'b11) begin
      miscompares++; $display("FAIL add_flags: got %b expected 11", {cf, zf});
    end
    beat(3'(AND), 0, 0, 8'h00, 2'b00, 0, 0); tick(); idle(); #1;
    vectors++;
    if ({cf, zf} !== 2'b11) begin
      miscompares++; $display("FAIL and_keeps_flags: got %b expected 11", {cf, zf});
    end
    beat(3'(ADD), 1, 7, 8'h42, 2'b00, 0, 0); tick(); idle(); ra1 = 7; #1;
    vectors++;
    if ({cf, zf, rd1} !== {2'b00, 8'h42}) begin
      miscompares++; $display("FAIL add_clear: got %b/%h expected 00/42", {cf, zf}, rd1);
    end
    vectors++;
    if (retired !== 16'd6) begin
      miscompares++; $display("FAIL retired_6: got %0d expected 6", retired);
    end
  endtask

  task automatic test_out_of_range();
    // Trap bit on an undefined opcode is not a trap; flags must not move.
    beat(3'b101, 1, 4, 8'h3C, 2'b11, 1, 1); tick(); idle(); ra2 = 4; #1;
    vectors++;
    if ({trapped, cf, zf, rd2} !== {3'b000, 8'h3C}) begin
      miscompares++; $display("FAIL op101: got %b/%h expected 000/3c", {trapped, cf, zf}, rd2);
    end
    beat(3'(XOR), 1, 2, 8'h55, 2'b00, 0, 1); tick(); idle(); #1;
    vectors++;
    if (trapped !== 1'b0 || retired !== 16'd8) begin
      miscompares++; $display("FAIL xor_trap_ignored: got %b/%0d expected 0/8", trapped, retired);
    end
  endtask

  task automatic test_trap();
    beat(3'(SHL), 1, 2, 8'hEE, 2'b00, 0, 1); tick();
    beat(3'(XOR), 1, 2, 8'h11, 2'b00, 0, 0); ra1 = 2; #1;
    vectors++;
    if ({trapped, wb.WB_READY} !== 2'b10 || trap_count !== 8'd1) begin
      miscompares++; $display("FAIL trap_enter: got %b/%0d expected 10/1", {trapped, wb.WB_READY}, trap_count);
    end
    vectors++;
    if (rd1 !== 8'h55 || retired !== 16'd8) begin
      miscompares++; $display("FAIL trap_no_commit: got %h/%0d expected 55/8", rd1, retired);
    end
    tick(); tick(); #1;
    vectors++;
    if (rd1 !== 8'h55 || retired !== 16'd8 || trapped !== 1'b1) begin
      miscompares++; $display("FAIL held_beat_blocked: got %h/%0d/%b expected 55/8/1", rd1, retired, trapped);
    end
  endtask

  task automatic test_trap_ack();
    trap_ack = 1; #1;
    vectors++;
    if (wb.WB_READY !== 1'b0) begin
      miscompares++; $display("FAIL ready_during_ack: got %b expected 0", wb.WB_READY);
    end
    tick(); trap_ack = 0; #1;
    vectors++;
    if ({wb.WB_READY, trapped, rd1} !== {2'b10, 8'h55}) begin
      miscompares++; $display("FAIL ack_release: got %b/%h expected 10/55", {wb.WB_READY, trapped}, rd1);
    end
    tick(); idle(); #1;
    vectors++;
    if (rd1 !== 8'h11 || retired !== 16'd9) begin
      miscompares++; $display("FAIL held_beat_commit: got %h/%0d expected 11/9", rd1, retired);
    end
    // Ack while running must change nothing.
    trap_ack = 1; tick(); trap_ack = 0; #1;
    vectors++;
    if ({wb.WB_READY, trapped} !== 2'b10) begin
      miscompares++; $display("FAIL ack_in_run: got %b expected 10", {wb.WB_READY, trapped});
    end
  endtask

  task automatic test_reset_in_trap();
    beat(3'(XOR), 1, 5, 8'h7F, 2'b00, 0, 0); tick();
    beat(3'(ADD), 0, 0, 8'h00, 2'b10, 1, 0); tick();
    beat(3'(SHR), 1, 5, 8'h00, 2'b00, 0, 1); tick();
    idle(); ra1 = 5; #1;
    vectors++;
    if ({trapped, cf, zf, rd1} !== {3'b111, 8'h7F} || trap_count !== 8'd2) begin
      miscompares++; $display("FAIL pre_reset: got %b/%h/%0d expected 111/7f/2", {trapped, cf, zf}, rd1, trap_count);
    end
    rst = 1; trap_ack = 1;
    beat(3'(XOR), 1, 6, 8'h99, 2'b00, 0, 0);
    tick(); rst = 0; trap_ack = 0; idle(); #1;
    vectors++;
    if ({wb.WB_READY, trapped, cf, zf} !== 4'b1000 || trap_count !== 8'd0 || retired !== 16'd0) begin
      miscompares++; $display("FAIL reset_in_trap: got %b/%0d/%0d expected 1000/0/0", {wb.WB_READY, trapped, cf, zf}, trap_count, retired);
    end
    for (int r = 0; r < 8; r++) begin
      ra1 = 3'(r); #1;
      vectors++;
      if (rd1 !== 8'h00) begin
        miscompares++; $display("FAIL reg_cleared r%0d: got %h expected 00", r, rd1);
      end
    end
  endtask

  task automatic test_trap_saturate();
    for (int i = 1; i <= 256; i++) begin
      beat(3'(SHL), 0, 0, 8'h00, 2'b00, 0, 1); tick(); idle();
      trap_ack = 1; tick(); trap_ack = 0; #1;
      if (i == 254 || i == 255 || i == 256) begin
        vectors++;
        if (trap_count !== ((i > 255) ? 8'd255 : 8'(i))) begin
          miscompares++; $display("FAIL trap_count_%0d: got %0d expected %0d", i, trap_count, (i > 255) ? 255 : i);
        end
      end
    end
    vectors++;
    if (retired !== 16'd0) begin
      miscompares++; $display("FAIL trap_not_retired: got %0d expected 0", retired);
    end
  endtask

  task automatic test_retired_wrap();
    beat(3'(AND), 0, 0, 8'h00, 2'b11, 1, 0);
    repeat (65535) tick();
    #1;
    vectors++;
    if (retired !== 16'hFFFF) begin
      miscompares++; $display("FAIL retired_max: got %h expected ffff", retired);
    end
    tick(); idle(); #1;
    vectors++;
    if (retired !== 16'h0000 || {cf, zf} !== 2'b00) begin
      miscompares++; $display("FAIL retired_wrap: got %h/%b expected 0000/00", retired, {cf, zf});
    end
  endtask

  initial begin
    rst = 1; trap_ack = 0; ra1 = 0; ra2 = 0;
    wb.WB_OP = 3'b000; wb.WB_DEST = 0; wb.WB_DATA = 0; wb.WB_OVERFLOW = 0; wb.WB_ZF = 0;
    idle();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_add_flags();
    test_out_of_range();
    test_trap();
    test_trap_ack();
    test_reset_in_trap();
    test_trap_saturate();
    test_retired_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
